// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter (CPU + DMA ports).
package mem_arb_pkg;

  localparam int CNT_W = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the port
// that was not served last.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  // Select the winning port index from the request pair.
  always_comb begin
    gnt   = PORT_CPU;
    valid = 1'b0;
    case (req)
      2'b01: begin
        gnt   = PORT_CPU;
        valid = 1'b1;
      end
      2'b10: begin
        gnt   = PORT_DMA;
        valid = 1'b1;
      end
      2'b11: begin
        gnt   = ~last;
        valid = 1'b1;
      end
      default: begin
        gnt   = PORT_CPU;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA accesses onto one fixed-latency memory with
// round-robin arbitration; cpu_stall holds the multicycle controller.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_dma
);

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             owner_r;
  logic             last_grant_r;
  logic             gnt_s;
  logic             gnt_valid_s;

  arb_rr2 u_rr (
    .req   ({dma_req, cpu_req}),
    .last  (last_grant_r),
    .gnt   (gnt_s),
    .valid (gnt_valid_s)
  );

  // The controller freezes on this until the completion pulse.
  assign cpu_stall = cpu_req & ~cpu_ready;

  // Transaction sequencer: grant, strobe, latency countdown, completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      owner_r      <= PORT_CPU;
      last_grant_r <= PORT_DMA;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      cpu_rdata    <= {DATA_W{1'b0}};
      dma_rdata    <= {DATA_W{1'b0}};
      cpu_ready    <= 1'b0;
      dma_ready    <= 1'b0;
      grant_dma    <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            owner_r      <= gnt_s;
            last_grant_r <= gnt_s;
            grant_dma    <= gnt_s;
            mem_en       <= 1'b1;
            state_r      <= ISSUE;
            if (gnt_s == PORT_DMA) begin
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        ISSUE: begin
          cnt_r   <= CNT_W'(MEM_LAT - 1);
          state_r <= WAIT;
        end
        WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            // Read data is only meaningful on this final cycle; writes leave rdata alone.
            if (!mem_we) begin
              if (owner_r == PORT_DMA) begin
                dma_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
            if (owner_r == PORT_DMA) begin
              dma_ready <= 1'b1;
            end else begin
              cpu_ready <= 1'b1;
            end
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          grant_dma <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (MEM_LAT 2, 1, 5) share
// stimulus; instance 0 feeds the ready/rdata scoreboard.
module tb_mem_arbiter;

  localparam logic [31:0] K    = 32'hDEADBEFF;
  localparam logic [31:0] GARB = 32'hBADBAD00;

  typedef struct {
    logic        port;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0, dma_addr = 32'h0, dma_wdata = 32'h0;

  logic [2:0] cpu_ready, dma_ready, cpu_stall, mem_en, mem_we, grant_dma;
  logic [2:0][31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ K;
  endfunction

  function automatic int lat_of(input int g);
    if (g == 0) return 2;
    else if (g == 1) return 1;
    else return 5;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    logic [31:0] pipe [5];
    logic [31:0] rd;
    always @(posedge clk) begin
      pipe[0] <= mem_en[g] ? (mem_addr[g] ^ K) : GARB;
      for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
    end
    assign rd = pipe[LAT-1];
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata[g]), .cpu_ready(cpu_ready[g]), .cpu_stall(cpu_stall[g]),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata[g]), .dma_ready(dma_ready[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(rd), .grant_dma(grant_dma[g])
    );
  end

  task automatic scoreboard_mon();
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_missed: no ready by cycle %0d, required port %0d ready at cycle %0d",
                 cyc, exp_q[0].port, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (!rst && (cpu_ready[0] || dma_ready[0])) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: cpu_ready=%0b dma_ready=%0b at cycle %0d, required no pulse",
                   cpu_ready[0], dma_ready[0], cyc);
        end else begin
          e = exp_q.pop_front();
          if (cpu_ready[0] === dma_ready[0] || dma_ready[0] !== e.port || cyc !== e.cyc ||
              (e.port ? dma_rdata[0] : cpu_rdata[0]) !== e.data) begin
            n_err++;
            $display("FAIL sb_ready: got cpu_ready=%0b dma_ready=%0b cycle=%0d rdata=%h, required port=%0d cycle=%0d rdata=%h",
                     cpu_ready[0], dma_ready[0], cyc, e.port ? dma_rdata[0] : cpu_rdata[0],
                     e.port, e.cyc, e.data);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    dma_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if ({mem_en[0], mem_we[0], cpu_ready[0], dma_ready[0], grant_dma[0]} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: en/we/crdy/drdy/gnt=%b, required 00000",
               {mem_en[0], mem_we[0], cpu_ready[0], dma_ready[0], grant_dma[0]});
    end
    n_cmp++;
    if ({mem_addr[0], mem_wdata[0], cpu_rdata[0], dma_rdata[0]} !== 128'h0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h, required all 0",
               mem_addr[0], mem_wdata[0], cpu_rdata[0], dma_rdata[0]);
    end
    n_cmp++;
    if (cpu_stall[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_stall_hi: cpu_stall=%b, required 1", cpu_stall[0]);
    end
    cpu_req = 1'b0;
    #1;
    n_cmp++;
    if (cpu_stall[0] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall_lo: cpu_stall=%b, required 0", cpu_stall[0]);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    int t0;
    do_reset();
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
    t0 = cyc;
    exp_q.push_back('{port: 1'b0, cyc: t0 + 4, data: 32'hDEADBEEF});
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin @(posedge clk); #2; end else #1;
      n_cmp++;
      if (mem_en[0] !== (c == 1)) begin
        n_err++;
        $display("FAIL read_mem_en c%0d: mem_en=%b, required %b", c, mem_en[0], (c == 1));
      end
      n_cmp++;
      if (cpu_stall[0] !== (c <= 3)) begin
        n_err++;
        $display("FAIL read_stall c%0d: cpu_stall=%b, required %b", c, cpu_stall[0], (c <= 3));
      end
      if (c == 1) begin
        n_cmp++;
        if (mem_addr[0] !== 32'h10 || mem_we[0] !== 1'b0) begin
          n_err++;
          $display("FAIL read_issue: mem_addr=%h mem_we=%b, required 00000010 0", mem_addr[0], mem_we[0]);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (cpu_rdata[0] !== 32'hDEADBEEF) begin
          n_err++;
          $display("FAIL read_rdata: cpu_rdata=%h, required deadbeef", cpu_rdata[0]);
        end
        cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    int t0;
    do_reset();
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 32'h20; dma_we = 1'b0; dma_addr = 32'h30;
    cpu_req = 1'b1; dma_req = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 6; k++)
      exp_q.push_back('{port: (k % 2 == 1), cyc: t0 + 4 + 5 * k,
                        data: mdata((k % 2 == 1) ? 32'h30 : 32'h20)});
    for (int c = 0; c <= 29; c++) begin
      if (c > 0) begin @(posedge clk); #2; end else #1;
      if (c % 5 == 1) begin
        n_cmp++;
        if (mem_en[0] !== 1'b1 || grant_dma[0] !== ((c / 5) % 2 == 1) ||
            mem_addr[0] !== (((c / 5) % 2 == 1) ? 32'h30 : 32'h20)) begin
          n_err++;
          $display("FAIL contention_grant c%0d: mem_en=%b grant_dma=%b mem_addr=%h, required 1 %b %h",
                   c, mem_en[0], grant_dma[0], mem_addr[0], ((c / 5) % 2 == 1),
                   ((c / 5) % 2 == 1) ? 32'h30 : 32'h20);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (cpu_rdata[0] !== mdata(32'h20)) begin
          n_err++;
          $display("FAIL contention_cpu_hold: cpu_rdata=%h, required %h", cpu_rdata[0], mdata(32'h20));
        end
      end
      if (c == 29) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
    end
  endtask

  task automatic test_dma_write();
    int t0;
    @(posedge clk); #1;
    dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234; dma_req = 1'b1;
    t0 = cyc;
    exp_q.push_back('{port: 1'b1, cyc: t0 + 4, data: mdata(32'h30)});
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin @(posedge clk); #2; end else #1;
      if (c == 1) begin
        n_cmp++;
        if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_wdata[0] !== 32'h1234 ||
            mem_addr[0] !== 32'h40 || grant_dma[0] !== 1'b1) begin
          n_err++;
          $display("FAIL write_issue: en=%b we=%b wdata=%h addr=%h gnt=%b, required 1 1 00001234 00000040 1",
                   mem_en[0], mem_we[0], mem_wdata[0], mem_addr[0], grant_dma[0]);
        end
      end
      if (c == 2) begin
        dma_addr = 32'h44;
        dma_wdata = 32'h9999;
      end
      if (c == 3) begin
        n_cmp++;
        if (mem_addr[0] !== 32'h40 || mem_wdata[0] !== 32'h1234) begin
          n_err++;
          $display("FAIL write_latched: addr=%h wdata=%h, required 00000040 00001234",
                   mem_addr[0], mem_wdata[0]);
        end
      end
      if (c == 4 || c == 5) begin
        n_cmp++;
        if (dma_rdata[0] !== mdata(32'h30) || cpu_rdata[0] !== mdata(32'h20)) begin
          n_err++;
          $display("FAIL write_rdata_hold c%0d: drd=%h crd=%h, required %h %h",
                   c, dma_rdata[0], cpu_rdata[0], mdata(32'h30), mdata(32'h20));
        end
        dma_req = 1'b0;
        dma_we = 1'b0;
      end
    end
  endtask

  task automatic test_latency();
    int t0;
    int seen [3];
    do_reset();
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 32'h50; cpu_req = 1'b1;
    t0 = cyc;
    exp_q.push_back('{port: 1'b0, cyc: t0 + 4, data: mdata(32'h50)});
    for (int g = 0; g < 3; g++) seen[g] = -1;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) begin @(posedge clk); #2; end else #1;
      for (int g = 0; g < 3; g++)
        if (cpu_ready[g] && seen[g] < 0) seen[g] = c;
      if (c == 3) cpu_req = 1'b0;
    end
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (seen[g] !== lat_of(g) + 2) begin
        n_err++;
        $display("FAIL latency_%0d: ready after %0d cycles, required %0d", lat_of(g), seen[g], lat_of(g) + 2);
      end
      n_cmp++;
      if (cpu_rdata[g] !== mdata(32'h50)) begin
        n_err++;
        $display("FAIL latency_%0d_data: cpu_rdata=%h, required %h", lat_of(g), cpu_rdata[g], mdata(32'h50));
      end
    end
  endtask

  task automatic test_reset_mid();
    int t1;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 32'h60; cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mem_en[0], mem_we[0], cpu_ready[0], dma_ready[0], grant_dma[0]} !== 5'b0 ||
        mem_addr[0] !== 32'h0 || cpu_rdata[0] !== 32'h0 || cpu_stall[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_async: ctrl=%b addr=%h crd=%h stall=%b, required 00000 0 0 1",
               {mem_en[0], mem_we[0], cpu_ready[0], dma_ready[0], grant_dma[0]},
               mem_addr[0], cpu_rdata[0], cpu_stall[0]);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    t1 = cyc;
    exp_q.push_back('{port: 1'b0, cyc: t1 + 4, data: mdata(32'h60)});
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin @(posedge clk); #2; end else #1;
      n_cmp++;
      if (mem_en[0] !== (c == 1)) begin
        n_err++;
        $display("FAIL midreset_regrant c%0d: mem_en=%b, required %b", c, mem_en[0], (c == 1));
      end
      if (c == 4) cpu_req = 1'b0;
    end
  endtask

  task automatic test_drop();
    int t0;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 32'h70; cpu_req = 1'b1;
    t0 = cyc;
    exp_q.push_back('{port: 1'b0, cyc: t0 + 4, data: mdata(32'h70)});
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin @(posedge clk); #2; end else #1;
      n_cmp++;
      if (mem_en[0] !== (c == 1)) begin
        n_err++;
        $display("FAIL drop_mem_en c%0d: mem_en=%b, required %b", c, mem_en[0], (c == 1));
      end
      if (c == 2) cpu_req = 1'b0;
      if (c == 3) begin
        n_cmp++;
        if (cpu_stall[0] !== 1'b0) begin
          n_err++;
          $display("FAIL drop_stall: cpu_stall=%b, required 0", cpu_stall[0]);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (cpu_rdata[0] !== mdata(32'h70)) begin
          n_err++;
          $display("FAIL drop_rdata: cpu_rdata=%h, required %h", cpu_rdata[0], mdata(32'h70));
        end
      end
    end
  endtask

  initial begin
    fork
      scoreboard_mon();
    join_none
    test_reset();
    test_cpu_read();
    test_contention();
    test_dma_write();
    test_latency();
    test_reset_mid();
    test_drop();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d expected completions outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the multicycle CPU's single unified memory between the CPU (instruction fetch and lw/sw traffic driven by the controller's MemRead/MemWrite/IorD path) and a DMA/loader requester. It serialises accesses through a fixed-latency memory, applies two-way round-robin arbitration and returns a `cpu_stall` the controller uses to hold its current state and suppress PCLoad until the access completes.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, memory read latency in cycles after the `mem_en` cycle; legal range 1..15
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cpu_req`  in  1  CPU access request; held until `cpu_ready`
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req`
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  registered read data, held until the next CPU read completes
- `cpu_ready`  out  1  one-cycle completion pulse
- `cpu_stall`  out  1  `cpu_req & ~cpu_ready`, combinational
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ready`: same semantics for the DMA port
- `mem_en`  out  1  one-cycle memory strobe
- `mem_we`  out  1  write enable, valid with `mem_en`
- `mem_addr`  out  ADDR_W  registered address
- `mem_wdata`  out  DATA_W  registered write data
- `mem_rdata`  in  DATA_W  valid exactly `MEM_LAT` cycles after the `mem_en` cycle
- `grant_dma`  out  1  1 while the DMA owns the current transaction (debug)

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** The arbiter samples both requests.
  - If only one request is active, it is granted.
  - If both are active, the port opposite to `last_grant` is granted.
  - On a grant: latch `we`/`addr`/`wdata` into the `mem_*` registers, set `owner`, update `last_grant`, and go to ISSUE.
  - With no request, remain in IDLE.
- **ISSUE:** `mem_en` = 1 for this cycle only. Load `cnt` = `MEM_LAT` - 1, then go to WAIT.
- **WAIT:** Decrement `cnt`. When `cnt` = 0, capture `mem_rdata` into the owner's `rdata` register (reads only) and go to DONE.
  - With `MEM_LAT` = 1, WAIT lasts one cycle.
- **DONE:** The owner's `ready` = 1. Both requests are ignored in this cycle. Go to IDLE.
- Writes use the same timeline as reads.
  - `mem_rdata` is not captured on a write.
  - `rdata` keeps its previous value.
- Request inputs are sampled only in IDLE.
  - If a requester drops `req` mid-transaction, the transaction still completes and `ready` still pulses.
  - Changes to `addr`/`wdata` after the grant are ignored.
- The ports are independent: `cpu_rdata` never changes on a DMA transaction, and vice versa.
- `cpu_stall` stays high through ISSUE/WAIT and is low in DONE. The controller advances its state on the DONE cycle.

## Timing
- Request first high in IDLE at cycle t gives:
  - `mem_en` at t+1
  - `mem_rdata` valid at t+1+`MEM_LAT`, captured at the end of that cycle
  - `ready` at t+2+`MEM_LAT`
  - IDLE at t+3+`MEM_LAT`
- Throughput is one access per `MEM_LAT`+3 cycles. With `MEM_LAT` = 2: `mem_en` at cycle 1, `ready` at cycle 4, next grant sampled at cycle 5.
- A request arriving during ISSUE/WAIT/DONE waits; it is sampled in the next IDLE.
- Under continuous contention the ports strictly alternate: CPU, DMA, CPU, ...
- Reset (asynchronous, any state):
  - state = IDLE, `last_grant` = DMA (so the CPU wins the first tie), `owner` = CPU, `cnt` = 0.
  - `mem_en`, `mem_we`, `cpu_ready`, `dma_ready`, `grant_dma` = 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `dma_rdata` = 0.
  - An in-flight transaction is dropped and no `ready` is issued.
  - `cpu_stall` follows `cpu_req` during reset.
- All outputs except `cpu_stall`/`dma_stall`-style terms are registered.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, DONE)
  - port constants `PORT_CPU` = 0, `PORT_DMA` = 1
  - `CNT_W` = 4
- Sub-module `arb_rr2`: combinational two-way round-robin picker with inputs `req[1:0]`, `last` and outputs `gnt`, `valid`. It is instantiated once inside `mem_arbiter`; `last_grant` is kept in the parent.

## Test plan
- CPU read alone, `MEM_LAT` = 2, addr 0x10, memory model returns 0xDEADBEEF:
  - `mem_en` at cycle 1 with `mem_addr` = 0x10, `mem_we` = 0
  - `cpu_ready` and `cpu_rdata` = 0xDEADBEEF at cycle 4
  - `cpu_stall` high for cycles 0–3
- Simultaneous CPU and DMA requests after reset:
  - CPU granted first, `dma_ready` at cycle 9
  - with both held continuously, grants alternate CPU/DMA for 6 transactions
- DMA write of 0x1234 to 0x40:
  - `mem_we` = 1 and `mem_wdata` = 0x1234 at cycle 1
  - `dma_ready` at cycle 4
  - `dma_rdata` and `cpu_rdata` unchanged
- `MEM_LAT` = 1 and `MEM_LAT` = 5 builds: `ready` arrives exactly `MEM_LAT`+2 cycles after `req`, and the captured data is correct.
- `rst` asserted during WAIT:
  - all outputs are 0 immediately (asynchronous) and no `ready` pulse occurs
  - after release, a held `cpu_req` is regranted from IDLE with full latency
- CPU drops `cpu_req` during WAIT: the transaction still completes, with `cpu_ready` at the nominal cycle and no second `mem_en`.
